// File: rtl/rr_arbiter3_if.sv
// Request/grant bundle for the three-way round-robin arbiter.
// A requester holds req[i] high for as long as it wants the resource; gnt[i] stays high
// while req[i] stays high (unless revoked), and dropping req[i] releases the grant.
interface rr_arbiter3_if;
   logic [2:0] req;
   logic       any_req;
   logic [2:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       dbg_state;

   modport master (output req, input any_req, input gnt, input gnt_id, input busy, input dbg_state);
   modport slave  (input req, output any_req, output gnt, output gnt_id, output busy, output dbg_state);
endinterface

// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter: registered one-hot grant, one dead cycle per
// handoff, and an optional hold-time limit that forces rotation under contention.
module rr_arbiter3 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         rst,
   rr_arbiter3_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

   state_e     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] owner_q, owner_d;
   logic [7:0] hold_q, hold_d;
   logic [2:0] gnt_q, gnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic       busy_q, busy_d;

   logic [1:0] cand1, cand2;
   logic [1:0] pick;
   logic       pick_vld;
   logic       owner_req;
   logic       others_req;
   logic       revoke;

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   function automatic logic [2:0] onehot3(input logic [1:0] v);
      return 3'b001 << v;
   endfunction

   // Search order starts at ptr and wraps mod 3; ptr never holds 3.
   always_comb begin
      cand1    = inc3(ptr_q);
      cand2    = inc3(cand1);
      pick     = 2'd0;
      pick_vld = 1'b0;
      if (bus.req[ptr_q]) begin
         pick     = ptr_q;
         pick_vld = 1'b1;
      end else if (bus.req[cand1]) begin
         pick     = cand1;
         pick_vld = 1'b1;
      end else if (bus.req[cand2]) begin
         pick     = cand2;
         pick_vld = 1'b1;
      end
   end

   always_comb begin
      owner_req  = bus.req[owner_q];
      others_req = |(bus.req & ~onehot3(owner_q));
      revoke     = (MAX_HOLD_C != 8'd0) && (hold_q >= MAX_HOLD_C) && others_req;
   end

   // Next-state process
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = GRANT;
               owner_d = pick;
               hold_d  = 8'd1;
            end
         end
         GRANT: begin
            if (!owner_req || revoke) begin
               state_d = IDLE;
               ptr_d   = inc3(owner_q);
               hold_d  = 8'd0;
            end else if (hold_q != 8'hFF) begin
               hold_d = hold_q + 8'd1;
            end
         end
      endcase
   end

   // Output process: values loaded into the output registers at the next edge
   always_comb begin
      gnt_d    = 3'b000;
      gnt_id_d = 2'b11;
      busy_d   = 1'b0;
      if (state_d == GRANT) begin
         gnt_d    = onehot3(owner_d);
         gnt_id_d = owner_d;
         busy_d   = 1'b1;
      end
   end

   // State register process
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= 2'd0;
         owner_q  <= 2'd0;
         hold_q   <= 8'd0;
         gnt_q    <= 3'b000;
         gnt_id_q <= 2'b11;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         hold_q   <= hold_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.any_req   = |bus.req;
   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.busy      = busy_q;
   assign bus.dbg_state = (state_q == GRANT);
endmodule

// File: tb/tb_rr_arbiter3.sv
// Bench for rr_arbiter3: two instances (MAX_HOLD=8 and MAX_HOLD=4) share one request
// stream and are checked every cycle against a behavioural round-robin model.
module tb_rr_arbiter3;
   logic       clk;
   logic       rst;
   logic [2:0] req;

   int n_checks;
   int n_errors;

   rr_arbiter3_if bus8 ();
   rr_arbiter3_if bus4 ();

   assign bus8.req = req;
   assign bus4.req = req;

   rr_arbiter3 u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   rr_arbiter3 #(.MAX_HOLD(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Per instance: current owner (-1 = none), next-priority index, cycles held so far.
   int         own  [2];
   int         ptr  [2];
   int         hold [2];
   int         mh   [2];
   bit         model_valid;
   logic [13:0] exp_q[$];

   function automatic logic [6:0] model_word(input int o);
      if (o < 0) return {1'b0, 2'b11, 3'b000, 1'b0};
      return {1'b1, 2'(o), 3'(1 << o), 1'b1};
   endfunction

   initial begin
      mh[0] = 8;
      mh[1] = 4;
      model_valid = 1'b0;
      for (int m = 0; m < 2; m++) begin
         own[m]  = -1;
         ptr[m]  = 0;
         hold[m] = 0;
      end
   end

   always @(posedge clk) begin
      logic [2:0] others;
      int c;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            own[m]  = -1;
            ptr[m]  = 0;
            hold[m] = 0;
         end else if (own[m] < 0) begin
            for (int k = 0; k < 3; k++) begin
               c = (ptr[m] + k) % 3;
               if (own[m] < 0 && req[c]) begin
                  own[m]  = c;
                  hold[m] = 1;
               end
            end
         end else begin
            others = req & ~(3'b001 << own[m]);
            if (!req[own[m]] || (mh[m] != 0 && hold[m] >= mh[m] && others != 3'b000)) begin
               ptr[m]  = (own[m] + 1) % 3;
               own[m]  = -1;
               hold[m] = 0;
            end else if (hold[m] < 255) begin
               hold[m] = hold[m] + 1;
            end
         end
      end
      if (rst) model_valid = 1'b1;
      if (model_valid) exp_q.push_back({model_word(own[0]), model_word(own[1])});
   end

   // ---------------- scoreboard compare (opposite edge) ----------------
   always @(negedge clk) begin
      logic [13:0] e;
      if (model_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("dut8_busy",   8'(bus8.busy),      8'(e[13]));
            chk("dut8_gnt_id", 8'(bus8.gnt_id),    8'(e[12:11]));
            chk("dut8_gnt",    8'(bus8.gnt),       8'(e[10:8]));
            chk("dut8_state",  8'(bus8.dbg_state), 8'(e[7]));
            chk("dut4_busy",   8'(bus4.busy),      8'(e[6]));
            chk("dut4_gnt_id", 8'(bus4.gnt_id),    8'(e[5:4]));
            chk("dut4_gnt",    8'(bus4.gnt),       8'(e[3:1]));
            chk("dut4_state",  8'(bus4.dbg_state), 8'(e[0]));
         end
         chk("dut8_any_req", 8'(bus8.any_req), 8'(|req));
         chk("dut4_any_req", 8'(bus4.any_req), 8'(|req));
      end
   end

   // ---------------- driver ----------------
   // Apply inputs, let one rising edge sample them, return 1 time unit after it.
   task automatic cyc(input logic [2:0] r, input logic rs);
      req = r;
      rst = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [2:0] exp8, input logic [2:0] exp4);
      chk({name, "_dut8"}, 8'(bus8.gnt), 8'(exp8));
      chk({name, "_dut4"}, 8'(bus4.gnt), 8'(exp4));
   endtask

   logic [2:0] rot_req [10] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b111,
                                3'b101, 3'b111, 3'b111, 3'b011, 3'b111};
   logic [2:0] rot_gnt [10] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                                3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
   logic [2:0] frc_req [6]  = '{3'b001, 3'b001, 3'b101, 3'b101, 3'b101, 3'b101};
   logic [2:0] frc_g4  [6]  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100};

   initial begin
      logic [2:0] r;
      n_checks = 0;
      n_errors = 0;
      req = 3'b000;
      rst = 1'b1;

      // Reset with all requests high
      cyc(3'b111, 1'b1);
      cyc(3'b111, 1'b1);
      lit("t1_reset_gnt", 3'b000, 3'b000);
      chk("t1_reset_gnt_id", 8'(bus8.gnt_id), 8'h3);
      chk("t1_reset_busy", 8'(bus8.busy), 8'h0);
      chk("t1_reset_any_req", 8'(bus8.any_req), 8'h1);
      cyc(3'b111, 1'b0);
      lit("t1_first_grant", 3'b001, 3'b001);

      // Single request, then ptr=2 priority
      cyc(3'b000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(3'b010, 1'b0);
         lit("t2_single_gnt", 3'b010, 3'b010);
         chk("t2_single_id", 8'(bus8.gnt_id), 8'h1);
      end
      cyc(3'b000, 1'b0);
      lit("t2_release", 3'b000, 3'b000);
      cyc(3'b111, 1'b0);
      lit("t2_ptr2", 3'b100, 3'b100);

      // Full rotation
      cyc(3'b111, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cyc(rot_req[i], 1'b0);
         lit("t3_rotation", rot_gnt[i], rot_gnt[i]);
      end

      // Forced rotation on the MAX_HOLD=4 instance; MAX_HOLD=8 keeps owner
      cyc(3'b000, 1'b1);
      for (int i = 0; i < 6; i++) begin
         cyc(frc_req[i], 1'b0);
         lit("t4_forced", 3'b001, frc_g4[i]);
      end

      // No contention: never revoked
      cyc(3'b000, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cyc(3'b001, 1'b0);
         lit("t5_no_contention", 3'b001, 3'b001);
      end

      // Reset mid-grant
      cyc(3'b000, 1'b1);
      cyc(3'b100, 1'b0);
      lit("t6_pre", 3'b100, 3'b100);
      cyc(3'b111, 1'b1);
      lit("t6_reset", 3'b000, 3'b000);
      cyc(3'b111, 1'b0);
      lit("t6_after", 3'b001, 3'b001);

      // Randomized: sticky request bits with occasional toggles and rare resets
      r = req;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         end
         cyc(r, ($urandom_range(0, 149) == 0));
      end

      cyc(3'b000, 1'b0);
      cyc(3'b000, 1'b0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/rr_arbiter3.md
# rr_arbiter3

Three-requester round-robin arbiter with grant locking and a hold-time limit. It shares one downstream resource, a single 3-input OR-merged return path, among three requesters. It also exports the combinational OR of all requests as an activity flag. Grants are registered and one-hot, and every handoff includes one dead (turnaround) cycle.

## Interface

- MAX_HOLD, default 8: maximum consecutive cycles one owner keeps the grant while another requester waits. 0 disables the limit. Legal range 0..255.

- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  3  request lines; bit i belongs to requester i
- any_req  output  1  combinational OR of req[2:0]
- gnt  output  3  registered one-hot grant; 3'b000 when no owner
- gnt_id  output  2  registered index of the owner; 2'b11 when no owner
- busy  output  1  registered; 1 when gnt != 0

## Operation

- State: FSM {IDLE, GRANT}, 2-bit ptr (next-highest-priority index, 0..2), 2-bit owner, 8-bit hold_cnt.
- Reset (rst=1 at an edge), regardless of state: state=IDLE, gnt=3'b000, gnt_id=2'b11, busy=0, ptr=0, hold_cnt=0. any_req still follows req, because it is combinational.
- IDLE:
  - If req != 0, pick the first set bit searching ptr, ptr+1, ptr+2 (mod 3).
  - Set gnt to that one-hot value, gnt_id and owner to that index, hold_cnt=1, and go to GRANT.
  - If req == 0, stay in IDLE and keep all outputs at their idle values.
- GRANT, release: if req[owner]=0, clear gnt, set gnt_id=2'b11, set ptr=(owner+1) mod 3, set hold_cnt=0, and go to IDLE.
- GRANT, revoke: if MAX_HOLD != 0, hold_cnt >= MAX_HOLD, and any other req bit is set, take the same actions as release (forced rotation).
- GRANT, otherwise: keep the grant. hold_cnt increments and saturates at 255.
  - With no competing request, the owner keeps the grant indefinitely.
- Release and revoke in the same cycle: handled as release, with an identical result.
- ptr changes only on release or revoke, never on a grant.
- A requester that drops and re-raises req during the dead cycle is a fresh request under the updated ptr.
- Requests that are not the owner are ignored while in GRANT; they are not queued or latched. The arbiter samples req only at edges.
- Width rules: index arithmetic is mod 3, and the value 3 never appears on ptr. hold_cnt compares unsigned against MAX_HOLD.

## Timing

- Request to grant: req sampled high at edge k while in IDLE gives gnt high after edge k (1-cycle latency).
- Release to idle: req[owner] sampled low at edge k gives gnt=0 after edge k. The earliest next grant appears after edge k+1, so there is exactly one dead cycle per handoff.
- Maximum contended hold: exactly MAX_HOLD cycles of gnt high, then one dead cycle, then the next owner.
- gnt, gnt_id and busy change only at rising edges.
- Outputs are glitch-free; any_req is the only combinational output.
- busy == (gnt != 0) and gnt_id always matches gnt in every cycle, including the cycle after reset.
- Reset mid-grant: rst=1 at edge k gives gnt=0 after edge k. After rst is released, the first grant follows ptr=0 priority.

## Test plan

1. **Reset.** Hold rst=1 for 2 cycles with req=3'b111. Then gnt=000, gnt_id=11, busy=0 and any_req=1. After rst falls, the next edge gives gnt=001.
2. **Single request.** From reset, raise req=3'b010 for 3 cycles, then drop it. Then:
   - gnt=010 and gnt_id=01 for exactly 3 cycles, starting 1 cycle after req rises.
   - gnt=000 follows.
   - Re-raising req=3'b111 gives gnt=100 (ptr=2).
3. **Full rotation.** Hold req=3'b111, with each owner dropping its bit for one cycle after holding 2 granted cycles. Grant order is 001, 010, 100, 001, with one gnt=000 cycle between each.
4. **Forced rotation** (MAX_HOLD=4). Hold req[0]=1 continuously and raise req[2] at cycle 2. Then gnt=001 for 4 cycles, one dead cycle, and gnt=100.
5. **No contention** (MAX_HOLD=4). Hold req=3'b001 for 20 cycles. Then gnt=001 continuously for 20 cycles, with no dead cycle.
6. **Reset mid-grant.** While gnt=100, assert rst for 1 cycle with req=3'b111. Then gnt=000 after that edge, and the next grant is 001.
